// File: rtl/fpu_fp64_mul_sched.sv
// Round-robin scheduler sharing one FP64 multiplier between two requesters.
// Ports: clk/reset_n; A and B req (valid/ready/srca/srcb); mul_* to multiplier;
//   rsp_valid/ready/id/data to consumer; busy; op_count (completed responses).
module fpu_fp64_mul_sched #(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [63:0]      a_srca,
    input  logic [63:0]      a_srcb,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [63:0]      b_srca,
    input  logic [63:0]      b_srcb,
    output logic             mul_enable,
    output logic [63:0]      mul_srca,
    output logic [63:0]      mul_srcb,
    input  logic [63:0]      mul_dst,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [63:0]      rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic [63:0]   op_a;
    logic [63:0]   op_b;
    logic          op_id;

    logic          grant_a;
    logic          grant_b;
    logic          accept;

    // last_grant: 0 = A, 1 = B; a tie goes to the other one.
    always_comb begin
        grant_a = a_valid && (!b_valid || last_grant);
        grant_b = b_valid && (!a_valid || !last_grant);
    end

    // Readies are masked by reset so they read 0 while reset is held.
    assign a_ready = reset_n && (state == S_IDLE) && grant_a;
    assign b_ready = reset_n && (state == S_IDLE) && grant_b;
    assign accept  = (a_valid && a_ready) || (b_valid && b_ready);

    assign mul_enable = (state == S_BUSY);
    assign rsp_valid  = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign mul_srca   = op_a;
    assign mul_srcb   = op_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            op_count   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_a       <= grant_b ? b_srca : a_srca;
                        op_b       <= grant_b ? b_srcb : a_srcb;
                        op_id      <= grant_b;
                        last_grant <= grant_b;
                        cnt        <= CW'(MUL_LAT);
                        state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        rsp_data <= mul_dst;
                        rsp_id   <= op_id;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        op_count <= op_count + CNT_W'(1);
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_fp64_mul_sched.sv
// Directed self-checking bench for fpu_fp64_mul_sched.
// Multiplier model: mul_dst = mul_enable ? srca ^ srcb : 0, MUL_LAT=3, CNT_W=4.
module tb_fpu_fp64_mul_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [63:0] a_srca = '0;
    logic [63:0] a_srcb = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [63:0] b_srca = '0;
    logic [63:0] b_srcb = '0;
    logic        mul_enable;
    logic [63:0] mul_srca;
    logic [63:0] mul_srcb;
    logic [63:0] mul_dst;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [63:0] rsp_data;
    logic        busy;
    logic [3:0]  op_count;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    assign mul_dst = mul_enable ? (mul_srca ^ mul_srcb) : 64'h0;

    fpu_fp64_mul_sched #(.MUL_LAT(3), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_srca(a_srca), .a_srcb(a_srcb),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_srca(b_srca), .b_srcb(b_srcb),
        .mul_enable(mul_enable), .mul_srca(mul_srca),
        .mul_srcb(mul_srcb), .mul_dst(mul_dst),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .op_count(op_count)
    );

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        a_valid = 1'b1;
        a_srca = 64'h5555_AAAA_1234_5678;
        a_srcb = 64'h0F0F_F0F0_8765_4321;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || mul_enable !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre busy=%b en=%b want 1 1", busy, mul_enable);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({a_ready, b_ready, mul_enable, rsp_valid, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b want 00000",
                     {a_ready, b_ready, mul_enable, rsp_valid, busy});
        end
        checks++;
        if (mul_srca !== 64'h0 || mul_srcb !== 64'h0) begin
            failures++;
            $display("FAIL reset_src a=%h b=%h want 0", mul_srca, mul_srcb);
        end
        checks++;
        if (rsp_data !== 64'h0 || rsp_id !== 1'b0 || op_count !== 4'h0) begin
            failures++;
            $display("FAIL reset_rsp d=%h id=%b cnt=%0d want 0", rsp_data, rsp_id, op_count);
        end
        a_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b ar=%b br=%b want 0", busy, a_ready, b_ready);
        end
        exp_cnt = 0;
    endtask

    task automatic test_single();
        @(negedge clk);
        a_valid = 1'b1;
        a_srca = 64'h3FF8_0000_0000_0000;
        a_srcb = 64'h4000_0000_0000_0000;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready ar=%b br=%b want 1 0", a_ready, b_ready);
        end
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++;
            if (mul_enable !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b1 ||
                mul_srca !== 64'h3FF8_0000_0000_0000 ||
                mul_srcb !== 64'h4000_0000_0000_0000) begin
                failures++;
                $display("FAIL single_busy%0d en=%b rv=%b busy=%b sa=%h sb=%h want 1 0 1",
                         k, mul_enable, rsp_valid, busy, mul_srca, mul_srcb);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || mul_enable !== 1'b0 || rsp_id !== 1'b0 ||
            rsp_data !== 64'h7FF8_0000_0000_0000) begin
            failures++;
            $display("FAIL single_rsp rv=%b en=%b id=%b d=%h want 1 0 0 7ff8000000000000",
                     rsp_valid, mul_enable, rsp_id, rsp_data);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL single_done rv=%b busy=%b cnt=%0d want 0 0 %0d",
                     rsp_valid, busy, op_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        int t;
        int bad;
        logic [63:0] exp_d;
        exp_d = 64'hC000_0000_0000_0002;
        @(negedge clk);
        b_valid = 1'b1;
        b_srca = 64'hC000_0000_0000_0001;
        b_srcb = 64'h0000_0000_0000_0003;
        #1;
        checks++;
        if (b_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_bready got=%b want 1", b_ready);
        end
        @(negedge clk);
        b_valid = 1'b0;
        a_valid = 1'b1;
        a_srca = 64'h1;
        a_srcb = 64'h2;
        rsp_ready = 1'b0;
        t = 0;
        #1;
        while (rsp_valid !== 1'b1 && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_timeout rsp_valid=%b want 1", rsp_valid);
        end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== exp_d ||
                a_ready !== 1'b0 || b_ready !== 1'b0 || op_count !== 4'(exp_cnt))
                bad++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold bad_cycles=%0d want 0 (d=%h id=%b cnt=%0d)",
                     bad, rsp_data, rsp_id, op_count);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 1;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || a_ready !== 1'b1 ||
            op_count !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL bp_release busy=%b rv=%b ar=%b cnt=%0d want 0 0 1 %0d",
                     busy, rsp_valid, a_ready, op_count, exp_cnt);
        end
        a_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_drop busy=%b want 0", busy);
        end
    endtask

    task automatic test_arbitration();
        int viol;
        int ngr;
        int nrsp;
        int t;
        logic drop;
        logic [3:0] grants;
        logic [3:0] rids;
        logic [63:0] rdat [4];
        logic [3:0] exp_order;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        exp_order = 4'b1010;
        exp_a = 64'h0123_4567_89AB_CDEF ^ 64'hFFFF_0000_FFFF_0000;
        exp_b = 64'h0000_0000_0000_0001 ^ 64'h8000_0000_0000_0000;
        do_reset();
        viol = 0;
        ngr = 0;
        nrsp = 0;
        t = 0;
        drop = 1'b0;
        grants = '0;
        rids = '0;
        @(negedge clk);
        a_valid = 1'b1;
        a_srca = 64'h0123_4567_89AB_CDEF;
        a_srcb = 64'hFFFF_0000_FFFF_0000;
        b_valid = 1'b1;
        b_srca = 64'h0000_0000_0000_0001;
        b_srcb = 64'h8000_0000_0000_0000;
        rsp_ready = 1'b1;
        while (nrsp < 4 && t < 60) begin
            #1;
            if (a_ready === 1'b1 && b_ready === 1'b1)
                viol++;
            if ((a_ready === 1'b1 || b_ready === 1'b1) && busy !== 1'b0)
                viol++;
            if ((a_ready === 1'b1 || b_ready === 1'b1) && ngr < 4) begin
                grants[ngr] = b_ready;
                ngr++;
            end
            if (ngr == 4)
                drop = 1'b1;
            if (rsp_valid === 1'b1) begin
                rids[nrsp] = rsp_id;
                rdat[nrsp] = rsp_data;
                nrsp++;
            end
            @(negedge clk);
            if (drop) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
            t++;
        end
        rsp_ready = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        checks++;
        if (nrsp != 4 || ngr != 4) begin
            failures++;
            $display("FAIL arb_timeout grants=%0d rsps=%0d want 4 4", ngr, nrsp);
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL arb_ready_excl violations=%0d want 0", viol);
        end
        checks++;
        if (grants !== exp_order) begin
            failures++;
            $display("FAIL arb_order got=%b want %b (bit0 first, 1=B)", grants, exp_order);
        end
        checks++;
        if (rids !== exp_order) begin
            failures++;
            $display("FAIL arb_rsp_id got=%b want %b", rids, exp_order);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdat[i] !== (exp_order[i] ? exp_b : exp_a)) begin
                failures++;
                $display("FAIL arb_data%0d got=%h want %h", i, rdat[i],
                         exp_order[i] ? exp_b : exp_a);
            end
        end
        exp_cnt = 4;
        #1;
        checks++;
        if (op_count !== 4'(exp_cnt) || busy !== 1'b0) begin
            failures++;
            $display("FAIL arb_count cnt=%0d busy=%b want %0d 0", op_count, busy, exp_cnt);
        end
    endtask

    task automatic test_abort();
        int seen;
        @(negedge clk);
        a_valid = 1'b1;
        a_srca = 64'hDEAD_BEEF_0000_0001;
        a_srcb = 64'h0000_0000_FFFF_FFFF;
        #1;
        checks++;
        if (a_ready !== 1'b1 || op_count !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL abort_pre ar=%b cnt=%0d want 1 %0d", a_ready, op_count, exp_cnt);
        end
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (mul_enable !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy2 en=%b want 1", mul_enable);
        end
        #1 reset_n = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (rsp_valid !== 1'b0)
                seen++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (seen != 0 || op_count !== 4'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_norsp rsp_cycles=%0d cnt=%0d busy=%b want 0 0 0",
                     seen, op_count, busy);
        end
    endtask

    task automatic test_wrap();
        int t;
        logic [63:0] exp_d;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_srca = {32'(i), 32'hA5A5_0000};
            a_srcb = 64'h0F0F_0F0F_0000_0000 | 64'(i);
            exp_d = a_srca ^ a_srcb;
            t = 0;
            #1;
            while (a_ready !== 1'b1 && t < 10) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (a_ready !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL wrap_accept_timeout op=%0d ar=%b want 1", i, a_ready);
                a_valid = 1'b0;
                break;
            end
            @(negedge clk);
            a_valid = 1'b0;
            a_srca = ~a_srca;
            a_srcb = 64'h0;
            t = 0;
            #1;
            while (rsp_valid !== 1'b1 && t < 10) begin
                @(negedge clk);
                #1;
                t++;
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d || op_count !== 4'(exp_cnt)) begin
                failures++;
                $display("FAIL wrap_rsp%0d rv=%b d=%h cnt=%0d want 1 %h %0d",
                         i, rsp_valid, rsp_data, op_count, exp_d, exp_cnt);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            exp_cnt = (exp_cnt + 1) % 16;
            #1;
            checks++;
            if (op_count !== 4'(exp_cnt)) begin
                failures++;
                $display("FAIL wrap_cnt%0d got=%0d want %0d", i, op_count, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_arbitration();
        test_abort();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
